// File: rtl/adxl345_spi_responder_if.sv
// 4-wire SPI bus between an ADXL345 master and the device-side responder.
interface adxl345_spi_responder_if;
  logic CS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output CS, output SCLK, output MOSI, input MISO);
  modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adxl345_spi_responder.sv
// ADXL345 SPI mode-3 device emulator: register map, sample latch and config mirrors.
// Optional macro ADXL345_RESP_SNAPSHOT_EN defers mid-frame samples until CS rises.
module adxl345_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic                          clk,
  input  logic                          reset_n,
  adxl345_spi_responder_if.slave        spi,
  input  logic [15:0]                   x_in,
  input  logic [15:0]                   y_in,
  input  logic [15:0]                   z_in,
  input  logic                          sample_valid,
  output logic [7:0]                    bw_rate,
  output logic [7:0]                    power_ctl,
  output logic [7:0]                    data_format,
  output logic                          wr_strobe,
  output logic [5:0]                    wr_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RD, S_WR} state_t;

  state_t      r_state;
  logic [1:0]  r_cs_sync;
  logic [1:0]  r_sclk_sync;
  logic [1:0]  r_mosi_sync;
  logic        r_cs_prev;
  logic        r_sclk_prev;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [5:0]  r_addr;
  logic        r_mb;
  logic        r_miso;
  logic [7:0]  r_bw_rate;
  logic [7:0]  r_power_ctl;
  logic [7:0]  r_data_format;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_z;
  logic        r_data_ready;
  logic        r_wr_strobe;
  logic [5:0]  r_wr_addr;
`ifdef ADXL345_RESP_SNAPSHOT_EN
  logic        r_pend;
  logic [15:0] r_pend_x;
  logic [15:0] r_pend_y;
  logic [15:0] r_pend_z;
  logic        w_cs_rise;
`endif

  logic        w_cs;
  logic        w_cs_fall;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_byte_done;
  logic        w_writable;
  logic [7:0]  w_rx_byte;
  logic [5:0]  w_next_addr;

  assign w_cs        = r_cs_sync[1];
  assign w_cs_fall   = r_cs_prev & ~w_cs;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
  assign w_rx_byte   = {r_rx_shift, r_mosi_sync[1]};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;
  assign w_writable  = (r_addr == 6'h2C) || (r_addr == 6'h2D) || (r_addr == 6'h31);
`ifdef ADXL345_RESP_SNAPSHOT_EN
  assign w_cs_rise   = ~r_cs_prev & w_cs;
`endif

  assign spi.MISO    = r_miso;
  assign bw_rate     = r_bw_rate;
  assign power_ctl   = r_power_ctl;
  assign data_format = r_data_format;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;

  function automatic logic [7:0] f_reg_read(input logic [5:0] a);
    case (a)
      6'h00:   f_reg_read = DEVID;
      6'h2C:   f_reg_read = r_bw_rate;
      6'h2D:   f_reg_read = r_power_ctl;
      6'h30:   f_reg_read = {r_data_ready, 7'b0};
      6'h31:   f_reg_read = r_data_format;
      6'h32:   f_reg_read = r_x[7:0];
      6'h33:   f_reg_read = r_x[15:8];
      6'h34:   f_reg_read = r_y[7:0];
      6'h35:   f_reg_read = r_y[15:8];
      6'h36:   f_reg_read = r_z[7:0];
      6'h37:   f_reg_read = r_z[15:8];
      default: f_reg_read = 8'h00;
    endcase
  endfunction

  // CS synchronizer resets low so a CS already low at reset release is not seen as a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync   <= 2'b00;
      r_cs_prev   <= 1'b0;
      r_sclk_sync <= 2'b11;
      r_sclk_prev <= 1'b1;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], spi.CS};
      r_cs_prev   <= r_cs_sync[1];
      r_sclk_sync <= {r_sclk_sync[0], spi.SCLK};
      r_sclk_prev <= r_sclk_sync[1];
      r_mosi_sync <= {r_mosi_sync[0], spi.MOSI};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 7'd0;
      r_tx_shift    <= 8'd0;
      r_addr        <= 6'd0;
      r_mb          <= 1'b0;
      r_miso        <= 1'b1;
      r_bw_rate     <= BW_RATE_RST;
      r_power_ctl   <= 8'h00;
      r_data_format <= 8'h00;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_z           <= 16'd0;
      r_data_ready  <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= 6'd0;
`ifdef ADXL345_RESP_SNAPSHOT_EN
      r_pend        <= 1'b0;
      r_pend_x      <= 16'd0;
      r_pend_y      <= 16'd0;
      r_pend_z      <= 16'd0;
`endif
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_cs) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b1;
      end else begin
        if (r_state != S_IDLE && w_sclk_rise) begin
          r_rx_shift <= w_rx_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        case (r_state)
          S_IDLE: begin
            r_miso <= 1'b1;
            if (w_cs_fall) begin
              r_state   <= S_ADDR;
              r_bit_cnt <= 3'd0;
            end
          end
          S_ADDR: begin
            if (w_byte_done) begin
              r_addr <= w_rx_byte[5:0];
              r_mb   <= w_rx_byte[6];
              if (w_rx_byte[7]) begin
                r_state    <= S_RD;
                r_tx_shift <= f_reg_read(w_rx_byte[5:0]);
              end else begin
                r_state <= S_WR;
              end
            end
          end
          S_RD: begin
            if (w_byte_done) begin
              r_addr     <= w_next_addr;
              r_tx_shift <= f_reg_read(w_next_addr);
              if (r_addr == 6'h37) r_data_ready <= 1'b0;
            end else if (w_sclk_fall) begin
              r_miso     <= r_tx_shift[7];
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
          S_WR: begin
            if (w_byte_done) begin
              r_addr <= w_next_addr;
              if (w_writable) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                case (r_addr)
                  6'h2C:   r_bw_rate     <= w_rx_byte;
                  6'h2D:   r_power_ctl   <= w_rx_byte;
                  6'h31:   r_data_format <= w_rx_byte;
                  default: ;
                endcase
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // Sample update sits after the read path so a same-cycle set beats the 0x37 clear.
`ifdef ADXL345_RESP_SNAPSHOT_EN
      if (sample_valid && !w_cs) begin
        r_pend   <= 1'b1;
        r_pend_x <= x_in;
        r_pend_y <= y_in;
        r_pend_z <= z_in;
      end else if (sample_valid) begin
        r_x          <= x_in;
        r_y          <= y_in;
        r_z          <= z_in;
        r_data_ready <= 1'b1;
        r_pend       <= 1'b0;
      end else if (r_pend && w_cs_rise) begin
        r_x          <= r_pend_x;
        r_y          <= r_pend_y;
        r_z          <= r_pend_z;
        r_data_ready <= 1'b1;
        r_pend       <= 1'b0;
      end
`else
      if (sample_valid) begin
        r_x          <= x_in;
        r_y          <= y_in;
        r_z          <= z_in;
        r_data_ready <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Scoreboard bench for adxl345_spi_responder: drives SPI frames, a monitor compares
// MISO bytes and write strobes against a frame-level register model.
module tb_adxl345_spi_responder;
  localparam int HALF = 110;  // SCLK half-period in ns: SCLK = clk/22

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] x_in = 16'd0;
  logic [15:0] y_in = 16'd0;
  logic [15:0] z_in = 16'd0;
  logic        sample_valid = 1'b0;
  logic [7:0]  bw_rate;
  logic [7:0]  power_ctl;
  logic [7:0]  data_format;
  logic        wr_strobe;
  logic [5:0]  wr_addr;

  adxl345_spi_responder_if spi_if();

  adxl345_spi_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (spi_if),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .sample_valid (sample_valid),
    .bw_rate      (bw_rate),
    .power_ctl    (power_ctl),
    .data_format  (data_format),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues: {check_enable, byte} per SPI byte, {addr, data} per write strobe
  logic [8:0]  rd_q[$];
  logic [13:0] wr_q[$];

  // Reference model of the device registers
  logic [7:0]  m_bw = 8'h0A;
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_df = 8'h00;
  logic [15:0] m_x = 16'd0, m_y = 16'd0, m_z = 16'd0;
  bit          m_dr = 1'b0;
  bit          p_valid = 1'b0;
  logic [15:0] p_x, p_y, p_z;

  logic [7:0]  d[8];
  logic [15:0] sx, sy, sz;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 6'h00) v = 8'hE5;
    else if (a == 6'h2C) v = m_bw;
    else if (a == 6'h2D) v = m_pc;
    else if (a == 6'h30) v = m_dr ? 8'h80 : 8'h00;
    else if (a == 6'h31) v = m_df;
    else if (a >= 6'h32 && a <= 6'h37) begin
      logic [15:0] s;
      s = (a < 6'h34) ? m_x : (a < 6'h36) ? m_y : m_z;
      v = a[0] ? s[15:8] : s[7:0];
    end
    return v;
  endfunction

  function automatic bit m_writable(input logic [5:0] a);
    return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h31);
  endfunction

  function automatic logic [7:0] reg_out(input logic [5:0] a);
    if (a == 6'h2C) return bw_rate;
    if (a == 6'h2D) return power_ctl;
    return data_format;
  endfunction

  // MISO monitor: acts like the master, sampling on SCLK rise
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [8:0] mon_e;
  always @(posedge spi_if.SCLK) begin
    if (spi_if.CS === 1'b0) begin
      mon_sh = {mon_sh[6:0], spi_if.MISO};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL miso_byte: got %h, expected no byte", mon_sh);
        end else begin
          mon_e = rd_q.pop_front();
          if (mon_e[8]) check("miso_byte", 16'(mon_sh), 16'(mon_e[7:0]));
        end
      end
    end
  end
  always @(posedge spi_if.CS) mon_cnt = 0;

  // Write-strobe monitor
  logic        prev_strobe = 1'b0;
  logic [13:0] wr_e;
  always @(negedge clk) begin
    if (reset_n && wr_strobe) begin
      n_checks++;
      if (prev_strobe) begin
        n_errors++;
        $display("FAIL wr_strobe_width: got 2+ clk, expected 1 clk");
      end
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_strobe: got strobe addr %h, expected none", wr_addr);
      end else begin
        wr_e = wr_q.pop_front();
        check("wr_addr", 16'(wr_addr), 16'(wr_e[13:8]));
        check("wr_reg", 16'(reg_out(wr_e[13:8])), 16'(wr_e[7:0]));
      end
    end
    prev_strobe = wr_strobe;
  end

  task automatic pulse_sample(input bit defer);
    @(negedge clk);
    x_in = sx; y_in = sy; z_in = sz;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    if (defer) begin
      p_valid = 1'b1; p_x = sx; p_y = sy; p_z = sz;
    end else begin
      m_x = sx; m_y = sy; m_z = sz; m_dr = 1'b1;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = b[7-i];
      #HALF;
      spi_if.SCLK = 1'b1;
      #HALF;
    end
  endtask

  // Full frame: expectations derived from the model first, then the bus is driven
  task automatic frame(input logic [7:0] cmd, input int n, input int sample_after);
    logic [5:0] a;
    a = cmd[5:0];
    rd_q.push_back({1'b1, 8'hFF});
    for (int i = 0; i < n; i++) begin
      if (cmd[7]) begin
        rd_q.push_back({1'b1, m_read(a)});
        if (a == 6'h37) m_dr = 1'b0;
      end else begin
        rd_q.push_back({1'b0, 8'h00});
        if (m_writable(a)) begin
          wr_q.push_back({a, d[i]});
          if (a == 6'h2C) m_bw = d[i];
          else if (a == 6'h2D) m_pc = d[i];
          else m_df = d[i];
        end
      end
      if (cmd[6]) a = a + 6'd1;
    end
    spi_if.CS = 1'b0;
    #HALF;
    spi_byte(cmd, 8);
    for (int i = 0; i < n; i++) begin
      spi_byte(d[i], 8);
      if (i == sample_after) pulse_sample(1'b1);
    end
    #HALF;
    spi_if.CS = 1'b1;
    #(4*HALF);
    if (p_valid) begin
      m_x = p_x; m_y = p_y; m_z = p_z; m_dr = 1'b1; p_valid = 1'b0;
    end
  endtask

  logic [5:0] pool[12] = '{6'h00, 6'h2C, 6'h2D, 6'h30, 6'h31, 6'h32,
                           6'h33, 6'h34, 6'h35, 6'h36, 6'h37, 6'h3F};

  initial begin
    spi_if.CS = 1'b1;
    spi_if.SCLK = 1'b1;
    spi_if.MOSI = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 8'h00;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    check("rst_miso", 16'(spi_if.MISO), 16'h1);
    check("rst_bw_rate", 16'(bw_rate), 16'h0A);
    check("rst_power_ctl", 16'(power_ctl), 16'h00);
    check("rst_data_format", 16'(data_format), 16'h00);
    check("rst_wr_strobe", 16'(wr_strobe), 16'h0);
    check("rst_wr_addr", 16'(wr_addr), 16'h00);

    frame(8'h80, 1, -1);
    d[0] = 8'h08;
    frame(8'h2D, 1, -1);

    sx = 16'h0001; sy = 16'hFFF0; sz = 16'h0100;
    pulse_sample(1'b0);
    frame(8'hB0, 1, -1);
    frame(8'hF2, 6, -1);
    frame(8'hB0, 1, -1);

    d[0] = 8'h55;
    frame(8'h00, 1, -1);
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    frame(8'h40, 3, -1);
    frame(8'h80, 1, -1);
    d[0] = 8'hA5; d[1] = 8'h3C;
    frame(8'h31, 2, -1);

    // Abort: CS raised after 5 bits of data byte 0x12 to 0x2C
    rd_q.push_back({1'b1, 8'hFF});
    spi_if.CS = 1'b0;
    #HALF;
    spi_byte(8'h2C, 8);
    spi_byte(8'h12, 5);
    spi_if.CS = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_miso", 16'(spi_if.MISO), 16'h1);
    check("abort_bw_rate", 16'(bw_rate), 16'(m_bw));
    #(4*HALF);
    frame(8'hAC, 1, -1);

`ifdef ADXL345_RESP_SNAPSHOT_EN
    sx = 16'h1234; sy = 16'($urandom); sz = 16'($urandom);
    frame(8'hF2, 6, 1);
    frame(8'hF2, 2, -1);
`endif

    for (int f = 0; f < 20; f++) begin
      logic [7:0] cmd;
      int n;
      if ($urandom_range(0, 1) == 1) begin
        sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
        pulse_sample(1'b0);
      end
      cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)]};
      n = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      frame(cmd, n, -1);
    end

    repeat (20) @(negedge clk);
    check("rd_q_empty", 16'(rd_q.size()), 16'd0);
    check("wr_q_empty", 16'(wr_q.size()), 16'd0);
    check("final_bw_rate", 16'(bw_rate), 16'(m_bw));
    check("final_power_ctl", 16'(power_ctl), 16'(m_pc));
    check("final_data_format", 16'(data_format), 16'(m_df));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
